// File: rtl/data_unpacker.sv
// Trace data unpacker: re-emits packed N-wide vectors as N, M or 1 element
// groups, one group per output beat, with the per-chain width taken from a
// firmware table loaded over the configId/configData shift bus.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   tracing                    enables new input accepts
//   valid_in, ready_out        packed vector handshake
//   vector_in, count_in        packed elements, valid ones in [N-1:N-count_in]
//   chainId_in                 chain of the incoming vector
//   configId, configData       firmware table shift bus
//   vector_out, length_out     unpacked group in [len-1:0], zeros above
//   chainId_out, last_out      chain of group, final group of the vector
//   valid_out, ready_in        output beat handshake
module data_unpacker #(
  parameter int N = 8,
  parameter int M = 2,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_CHAINS = 4,
  parameter logic [7:0] PERSONAL_CONFIG_ID = 8'd0,
  parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE = '0,
  localparam int CW = $clog2(N+1),
  localparam int CHW = $clog2(MAX_CHAINS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tracing,
  input  logic                    valid_in,
  output logic                    ready_out,
  input  logic [DATA_WIDTH*N-1:0] vector_in,
  input  logic [CW-1:0]           count_in,
  input  logic [CHW-1:0]          chainId_in,
  input  logic [7:0]              configId,
  input  logic [7:0]              configData,
  output logic [DATA_WIDTH*N-1:0] vector_out,
  output logic [CW-1:0]           length_out,
  output logic [CHW-1:0]          chainId_out,
  output logic                    last_out,
  output logic                    valid_out,
  input  logic                    ready_in
);

  typedef enum logic {IDLE, UNPACK} state_e;

  state_e                  state_q;
  logic [7:0]              fw_q [MAX_CHAINS];
  logic [DATA_WIDTH*N-1:0] held_q;
  logic [CW-1:0]           pos_q;
  logic [CW-1:0]           rem_q;
  logic [DATA_WIDTH*N-1:0] vec_q;
  logic [CW-1:0]           len_q;
  logic [CHW-1:0]          chain_q;
  logic                    last_q;
  logic                    valid_q;

  logic          hs;
  logic          accept;
  logic [7:0]    mode;
  logic [CW-1:0] acc_len;
  logic [CW-1:0] acc_groups;
  logic [CW-1:0] acc_base;

  assign hs        = valid_q && ready_in;
  assign ready_out = tracing && !reset &&
                     (state_q == IDLE || (hs && last_q));
  assign accept    = valid_in && ready_out;
  assign acc_base  = CW'(N) - count_in;

  assign vector_out  = vec_q;
  assign length_out  = len_q;
  assign chainId_out = chain_q;
  assign last_out    = last_q;
  assign valid_out   = valid_q;

  // Unknown modes leave groups at zero, so the vector is dropped.
  always_comb begin
    mode       = fw_q[chainId_in];
    acc_len    = '0;
    acc_groups = '0;
    unique case (1'b1)
      mode == 8'd0: begin
        acc_len    = CW'(N);
        acc_groups = count_in / CW'(N);
      end
      mode == 8'd1: begin
        acc_len    = CW'(M);
        acc_groups = count_in / CW'(M);
      end
      mode == 8'd2: begin
        acc_len    = CW'(1);
        acc_groups = count_in;
      end
      default: ;
    endcase
  end

  function automatic logic [DATA_WIDTH*N-1:0] grp(
    input logic [DATA_WIDTH*N-1:0] v,
    input int                      base,
    input int                      len
  );
    logic [DATA_WIDTH*N-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++) begin
      if (j < len && base + j < N)
        r[j*DATA_WIDTH +: DATA_WIDTH] =
          v[(base+j)*DATA_WIDTH +: DATA_WIDTH];
    end
    return r;
  endfunction

  // pos_q points at the next group to show; rem_q counts groups after
  // the one currently on the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      held_q  <= '0;
      pos_q   <= '0;
      rem_q   <= '0;
      vec_q   <= '0;
      len_q   <= '0;
      chain_q <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int i = 0; i < MAX_CHAINS; i++)
        fw_q[i] <= INITIAL_FIRMWARE[i*8 +: 8];
    end else begin
      if (configId == PERSONAL_CONFIG_ID) begin
        for (int i = 0; i < MAX_CHAINS-1; i++)
          fw_q[i] <= fw_q[i+1];
        fw_q[MAX_CHAINS-1] <= configData;
      end
      if (accept) begin
        held_q <= vector_in;
        if (acc_groups != '0) begin
          state_q <= UNPACK;
          valid_q <= 1'b1;
          vec_q   <= grp(vector_in, int'(acc_base), int'(acc_len));
          len_q   <= acc_len;
          chain_q <= chainId_in;
          last_q  <= (acc_groups == CW'(1));
          pos_q   <= acc_base + acc_len;
          rem_q   <= acc_groups - CW'(1);
        end else begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
      end else if (hs) begin
        if (last_q) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end else begin
          vec_q  <= grp(held_q, int'(pos_q), int'(len_q));
          last_q <= (rem_q == CW'(1));
          pos_q  <= pos_q + len_q;
          rem_q  <= rem_q - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_data_unpacker.sv
// Directed bench for data_unpacker (N=8, M=2, DATA_WIDTH=32).
// Firmware programmed to fw = {1, 2, 0, 3} for chains 0..3.
module tb_data_unpacker;

  localparam int N  = 8;
  localparam int DW = 32;
  typedef logic [DW*N-1:0] vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       tracing;
  logic       valid_in;
  logic       ready_out;
  vec_t       vector_in;
  logic [3:0] count_in;
  logic [1:0] chainId_in;
  logic [7:0] configId;
  logic [7:0] configData;
  vec_t       vector_out;
  logic [3:0] length_out;
  logic [1:0] chainId_out;
  logic       last_out;
  logic       valid_out;
  logic       ready_in;

  int checks = 0;
  int errors = 0;

  data_unpacker dut (
    .clk         (clk),
    .reset       (reset),
    .tracing     (tracing),
    .valid_in    (valid_in),
    .ready_out   (ready_out),
    .vector_in   (vector_in),
    .count_in    (count_in),
    .chainId_in  (chainId_in),
    .configId    (configId),
    .configData  (configData),
    .vector_out  (vector_out),
    .length_out  (length_out),
    .chainId_out (chainId_out),
    .last_out    (last_out),
    .valid_out   (valid_out),
    .ready_in    (ready_in)
  );

  always #5 clk = ~clk;

  function automatic vec_t ramp(input int s);
    vec_t v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(s + i);
    return v;
  endfunction

  function automatic vec_t pair(input int a, input int b);
    vec_t v;
    v = '0;
    v[DW-1:0]    = DW'(a);
    v[2*DW-1:DW] = DW'(b);
    return v;
  endfunction

  function automatic vec_t one(input int a);
    vec_t v;
    v = '0;
    v[DW-1:0] = DW'(a);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [7:0] d);
    configId   = 8'h00;
    configData = d;
    tick();
    configId   = 8'hFF;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    valid_in = 1'b1;
    tick();
    tick();
    checks++;
    if ({valid_out, last_out, vector_out, length_out, chainId_out,
         ready_out} !== '0) begin
      errors++;
      $display("FAIL reset_state: v=%0b l=%0b vec=%h len=%0d ch=%0d rdy=%0b, want all 0",
               valid_out, last_out, vector_out, length_out, chainId_out,
               ready_out);
    end
    reset    = 1'b0;
    valid_in = 1'b0;
    tick();
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %0b want 1", ready_out);
    end
  endtask

  task automatic test_mode1();
    vec_t e;
    valid_in   = 1'b1;
    vector_in  = ramp(0);
    count_in   = 4'd8;
    chainId_in = 2'd0;
    tick();
    valid_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      e = pair(2*k, 2*k+1);
      checks++;
      if ({valid_out, vector_out, length_out, last_out, ready_out,
           chainId_out} !== {1'b1, e, 4'd2, k == 3, k == 3, 2'd0}) begin
        errors++;
        $display("FAIL mode1_beat%0d: v=%0b vec=%h len=%0d l=%0b rdy=%0b ch=%0d, want vec=%h len=2 l=%0b rdy=%0b",
                 k, valid_out, vector_out, length_out, last_out, ready_out,
                 chainId_out, e, k == 3, k == 3);
      end
      tick();
    end
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL mode1_end: valid_out=%0b want 0", valid_out);
    end
  endtask

  task automatic test_mode2();
    vec_t v;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = 32'hDEAD;
    v[5*DW +: DW] = 32'hA;
    v[6*DW +: DW] = 32'hB;
    v[7*DW +: DW] = 32'hC;
    valid_in   = 1'b1;
    vector_in  = v;
    count_in   = 4'd3;
    chainId_in = 2'd1;
    tick();
    valid_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({valid_out, vector_out, length_out, last_out, chainId_out} !==
          {1'b1, one(10 + k), 4'd1, k == 2, 2'd1}) begin
        errors++;
        $display("FAIL mode2_beat%0d: v=%0b vec=%h len=%0d l=%0b ch=%0d, want vec=%h len=1 l=%0b ch=1",
                 k, valid_out, vector_out, length_out, last_out, chainId_out,
                 one(10 + k), k == 2);
      end
      tick();
    end
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL mode2_end: valid_out=%0b want 0", valid_out);
    end
  endtask

  task automatic test_leftover();
    valid_in   = 1'b1;
    vector_in  = ramp(40);
    count_in   = 4'd3;
    chainId_in = 2'd0;
    tick();
    valid_in = 1'b0;
    checks++;
    if ({valid_out, vector_out, length_out, last_out} !==
        {1'b1, pair(45, 46), 4'd2, 1'b1}) begin
      errors++;
      $display("FAIL leftover_beat: v=%0b vec=%h len=%0d l=%0b, want vec=%h len=2 l=1",
               valid_out, vector_out, length_out, last_out, pair(45, 46));
    end
    tick();
    valid_in   = 1'b1;
    count_in   = 4'd5;
    chainId_in = 2'd2;
    tick();
    valid_in = 1'b0;
    checks++;
    if ({valid_out, ready_out} !== 2'b01) begin
      errors++;
      $display("FAIL zero_groups: v=%0b rdy=%0b, want v=0 rdy=1",
               valid_out, ready_out);
    end
  endtask

  task automatic test_back_to_back();
    valid_in   = 1'b1;
    vector_in  = ramp(100);
    count_in   = 4'd8;
    chainId_in = 2'd2;
    tick();
    for (int j = 0; j < 3; j++) begin
      checks++;
      if ({valid_out, vector_out, length_out, last_out, ready_out,
           chainId_out} !== {1'b1, ramp(100 + 10*j), 4'd8, 1'b1, 1'b1,
                             2'd2}) begin
        errors++;
        $display("FAIL b2b_beat%0d: v=%0b vec=%h len=%0d l=%0b rdy=%0b ch=%0d, want vec=%h len=8 l=1 rdy=1",
                 j, valid_out, vector_out, length_out, last_out, ready_out,
                 chainId_out, ramp(100 + 10*j));
      end
      if (j < 2) vector_in = ramp(100 + 10*(j+1));
      else valid_in = 1'b0;
      tick();
    end
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: valid_out=%0b want 0", valid_out);
    end
  endtask

  task automatic test_backpressure();
    valid_in   = 1'b1;
    vector_in  = ramp(16);
    count_in   = 4'd8;
    chainId_in = 2'd0;
    tick();
    valid_in = 1'b0;
    checks++;
    if (vector_out !== pair(16, 17)) begin
      errors++;
      $display("FAIL bp_beat0: got %h want %h", vector_out, pair(16, 17));
    end
    tick();
    ready_in = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({valid_out, vector_out, length_out, last_out, ready_out} !==
          {1'b1, pair(18, 19), 4'd2, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold%0d: v=%0b vec=%h len=%0d l=%0b rdy=%0b, want vec=%h len=2 l=0 rdy=0",
                 c, valid_out, vector_out, length_out, last_out, ready_out,
                 pair(18, 19));
      end
      if (c == 3) ready_in = 1'b1;
      tick();
    end
    for (int k = 2; k < 4; k++) begin
      checks++;
      if ({valid_out, vector_out, last_out} !==
          {1'b1, pair(2*k + 16, 2*k + 17), k == 3}) begin
        errors++;
        $display("FAIL bp_beat%0d: v=%0b vec=%h l=%0b, want vec=%h l=%0b",
                 k, valid_out, vector_out, last_out,
                 pair(2*k + 16, 2*k + 17), k == 3);
      end
      tick();
    end
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL bp_end: valid_out=%0b want 0", valid_out);
    end
  endtask

  task automatic test_drop();
    valid_in   = 1'b1;
    vector_in  = ramp(60);
    count_in   = 4'd8;
    chainId_in = 2'd3;
    tick();
    checks++;
    if ({valid_out, ready_out} !== 2'b01) begin
      errors++;
      $display("FAIL drop: v=%0b rdy=%0b, want v=0 rdy=1",
               valid_out, ready_out);
    end
    vector_in  = ramp(70);
    chainId_in = 2'd0;
    tick();
    valid_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({valid_out, vector_out, last_out} !==
          {1'b1, pair(70 + 2*k, 71 + 2*k), k == 3}) begin
        errors++;
        $display("FAIL after_drop_beat%0d: v=%0b vec=%h l=%0b, want vec=%h l=%0b",
                 k, valid_out, vector_out, last_out,
                 pair(70 + 2*k, 71 + 2*k), k == 3);
      end
      tick();
    end
  endtask

  task automatic test_tracing();
    tracing    = 1'b0;
    valid_in   = 1'b1;
    vector_in  = ramp(30);
    count_in   = 4'd8;
    chainId_in = 2'd0;
    #1;
    checks++;
    if (ready_out !== 1'b0) begin
      errors++;
      $display("FAIL trace_off_ready: got %0b want 0", ready_out);
    end
    tick();
    tick();
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL trace_off_accept: valid_out=%0b want 0", valid_out);
    end
    tracing = 1'b1;
    tick();
    valid_in = 1'b0;
    tracing  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({valid_out, vector_out, last_out, ready_out} !==
          {1'b1, pair(30 + 2*k, 31 + 2*k), k == 3, 1'b0}) begin
        errors++;
        $display("FAIL trace_drain_beat%0d: v=%0b vec=%h l=%0b rdy=%0b, want vec=%h l=%0b rdy=0",
                 k, valid_out, vector_out, last_out, ready_out,
                 pair(30 + 2*k, 31 + 2*k), k == 3);
      end
      tick();
    end
    tracing = 1'b1;
  endtask

  task automatic test_reset_mid();
    valid_in   = 1'b1;
    vector_in  = ramp(80);
    count_in   = 4'd8;
    chainId_in = 2'd0;
    tick();
    valid_in = 1'b0;
    tick();
    checks++;
    if (vector_out !== pair(82, 83)) begin
      errors++;
      $display("FAIL rmid_beat1: got %h want %h", vector_out, pair(82, 83));
    end
    reset = 1'b1;
    #1;
    checks++;
    if (ready_out !== 1'b0) begin
      errors++;
      $display("FAIL rmid_ready: got %0b want 0", ready_out);
    end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({valid_out, vector_out, length_out} !== '0) begin
        errors++;
        $display("FAIL rmid_idle%0d: v=%0b vec=%h len=%0d, want all 0",
                 c, valid_out, vector_out, length_out);
      end
      tick();
    end
    valid_in  = 1'b1;
    vector_in = ramp(90);
    tick();
    valid_in = 1'b0;
    checks++;
    if ({valid_out, vector_out, length_out, last_out} !==
        {1'b1, ramp(90), 4'd8, 1'b1}) begin
      errors++;
      $display("FAIL rmid_fw_init: v=%0b vec=%h len=%0d l=%0b, want vec=%h len=8 l=1",
               valid_out, vector_out, length_out, last_out, ramp(90));
    end
    tick();
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL rmid_end: valid_out=%0b want 0", valid_out);
    end
  endtask

  initial begin
    reset      = 1'b1;
    tracing    = 1'b1;
    valid_in   = 1'b0;
    vector_in  = '0;
    count_in   = '0;
    chainId_in = '0;
    configId   = 8'hFF;
    configData = 8'h00;
    ready_in   = 1'b1;
    test_reset();
    cfg(8'd1);
    cfg(8'd2);
    cfg(8'd0);
    cfg(8'd3);
    test_mode1();
    test_mode2();
    test_leftover();
    test_back_to_back();
    test_backpressure();
    test_drop();
    test_tracing();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
